// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and default widths.
package arith_pkg;

   localparam int ARITH_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder.
interface serial_adder_if import arith_pkg::*; #(
   parameter int WIDTH = ARITH_W
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  ready, busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output ready, busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder: one full-adder cell plus carry FF.
module serial_adder import arith_pkg::*; #(
   parameter int WIDTH = ARITH_W
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   sa_state_t        r_state;
   sa_state_t        w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum_sh;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum_next;

   full_adder u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign w_accept   = (r_state == IDLE) && bus.start;
   assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Result registers only change on the final bit, so RUN never disturbs them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sum_sh <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a      <= r_a >> 1;
         r_b      <= r_b >> 1;
         r_sum_sh <= w_sum_next;
         r_carry  <= w_c;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;
         end
      end
   end

   assign bus.ready = (r_state == IDLE);
   assign bus.busy  = (r_state == RUN);
   assign bus.done  = (r_state == DONE);
   assign bus.sum   = r_sum;
   assign bus.cout  = r_cout;
   assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and streamed checks of serial_adder at WIDTH=8.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = c;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      bus.cin   = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
      int lat;
      apply(a, b, c);
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      wait_done(lat);
      check({tag, " latency"}, 32'(lat), 32'd8);
      check({tag, " sum"}, 32'(bus.sum), 32'(es));
      check({tag, " cout"}, 32'(bus.cout), 32'(ec));
      check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
      @(negedge clk);
      check({tag, " done pulse"}, 32'(bus.done), 32'd0);
      check({tag, " ready back"}, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      int         lat;
      int         cyc;
      int         acc;
      int         dn;
      int         last_acc;
      int         last_dn;
      logic [8:0] t;
      logic [9:0] e;
      logic [9:0] q[$];

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst ready", 32'(bus.ready), 32'd1);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst sum", 32'(bus.sum), 32'd0);
      check("rst cout", 32'(bus.cout), 32'd0);
      check("rst ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;

      op("35+4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      op("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start pulsed at edge 3 while busy must be ignored
      apply(8'h10, 8'h20, 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hAA;
      bus.b     = 8'h55;
      bus.cin   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("ign busy", 32'(bus.busy), 32'd1);
      wait_done(lat);
      check("ign latency", 32'(lat), 32'd5);
      check("ign sum", 32'(bus.sum), 32'h30);
      check("ign cout", 32'(bus.cout), 32'd0);
      @(negedge clk);
      check("ign ready", 32'(bus.ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ign no restart", 32'(bus.busy), 32'd0);
      end

      // asynchronous reset mid-RUN
      apply(8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid rst ready", 32'(bus.ready), 32'd1);
      check("mid rst busy", 32'(bus.busy), 32'd0);
      check("mid rst sum", 32'(bus.sum), 32'd0);
      check("mid rst cout", 32'(bus.cout), 32'd0);
      check("mid rst ovf", 32'(bus.ovf), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("mid rst no done", 32'(bus.done), 32'd0);
         if (i == 2) rst = 1'b0;
      end
      op("01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // start held high: 200 random operand sets against a+b+cin
      cyc      = 0;
      acc      = 0;
      dn       = 0;
      last_acc = -1;
      last_dn  = -1;
      while (dn < 200 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bus.done === 1'b1) begin
            e = (q.size() > 0) ? q.pop_front() : 10'h3FF;
            check("strm sum", 32'(bus.sum), 32'(e[7:0]));
            check("strm cout", 32'(bus.cout), 32'(e[8]));
            check("strm ovf", 32'(bus.ovf), 32'(e[9]));
            if (last_dn >= 0) check("strm done period", 32'(cyc - last_dn), 32'd10);
            last_dn = cyc;
            dn++;
         end
         if (bus.ready === 1'b1) begin
            if (acc < 200) begin
               bus.start = 1'b1;
               bus.a     = 8'($urandom);
               bus.b     = 8'($urandom);
               bus.cin   = 1'($urandom);
               t = {1'b0, bus.a} + {1'b0, bus.b} + {8'd0, bus.cin};
               e[7:0] = t[7:0];
               e[8]   = t[8];
               e[9]   = (bus.a[7] == bus.b[7]) && (t[7] != bus.a[7]);
               q.push_back(e);
               if (last_acc >= 0) check("strm accept period", 32'(cyc - last_acc), 32'd10);
               last_acc = cyc;
               acc++;
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check("strm done count", 32'(dn), 32'd200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
